// File: rtl/dataplane_tx_pkg.sv
// Shared definitions for the transmit egress path: shaper state encoding,
// default frame limits and a saturating counter helper.
package dataplane_tx_pkg;

    typedef enum logic [2:0] {
        PASS = 3'd0,
        PAD  = 3'd1,
        DROP = 3'd2,
        TAIL = 3'd3,
        GAP  = 3'd4
    } tx_state_e;

    localparam int DEF_MIN_FRAME = 60;
    localparam int DEF_MAX_FRAME = 1518;
    localparam int DEF_IFG       = 12;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/tx_frame_shaper.sv
// MAC egress shaper: pads runts to MIN_FRAME, truncates at MAX_FRAME, enforces
// an inter-frame gap and keeps saturating frame statistics.
module tx_frame_shaper
    import dataplane_tx_pkg::*;
#(
    parameter int MIN_FRAME  = DEF_MIN_FRAME,
    parameter int MAX_FRAME  = DEF_MAX_FRAME,
    parameter int IFG_CYCLES = DEF_IFG,
    parameter int CNT_W      = 16,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [7:0]        m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_padded,
    output logic [STAT_W-1:0] stat_truncated,
    output logic              trunc_pulse,
    output logic [2:0]        dbg_state
);

    localparam int GAP_W = 16;
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_FRAME);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FRAME);

    // Handshake: a byte moves on a port in any cycle where valid and ready are
    // both high at the rising clock edge; valid never waits on ready.
    tx_state_e          state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               frame_padded;
    logic               frame_trunc;

    logic               load_slot;
    logic               m_hs;
    logic               s_acc;
    logic [CNT_W-1:0]   n;

    assign load_slot = !m_valid || m_ready;
    assign m_hs      = m_valid && m_ready;
    assign s_acc     = s_valid && s_ready;
    assign n         = byte_cnt + CNT_W'(1);
    assign dbg_state = state;

    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (state)
                PASS:    s_ready = load_slot;
                DROP:    s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= PASS;
            byte_cnt       <= '0;
            gap_cnt        <= '0;
            frame_padded   <= 1'b0;
            frame_trunc    <= 1'b0;
            m_valid        <= 1'b0;
            m_data         <= 8'h00;
            m_last         <= 1'b0;
            trunc_pulse    <= 1'b0;
            stat_frames    <= '0;
            stat_padded    <= '0;
            stat_truncated <= '0;
        end else begin
            trunc_pulse <= 1'b0;

            if (m_hs && m_last) begin
                stat_frames <= STAT_W'(sat_inc(64'(stat_frames), STAT_W));
                if (frame_padded)
                    stat_padded <= STAT_W'(sat_inc(64'(stat_padded), STAT_W));
                if (frame_trunc)
                    stat_truncated <= STAT_W'(sat_inc(64'(stat_truncated), STAT_W));
            end

            case (state)
                PASS: begin
                    if (s_acc) begin
                        m_valid  <= 1'b1;
                        m_data   <= s_data;
                        byte_cnt <= n;
                        if (s_last) begin
                            if (n >= MIN_C) begin
                                m_last <= 1'b1;
                                state  <= TAIL;
                            end else begin
                                m_last       <= 1'b0;
                                frame_padded <= 1'b1;
                                state        <= PAD;
                            end
                        end else if (n == MAX_C) begin
                            m_last      <= 1'b1;
                            trunc_pulse <= 1'b1;
                            frame_trunc <= 1'b1;
                            state       <= DROP;
                        end else begin
                            m_last <= 1'b0;
                        end
                    end else if (m_hs) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end

                PAD: begin
                    if (load_slot) begin
                        m_valid  <= 1'b1;
                        m_data   <= 8'h00;
                        byte_cnt <= n;
                        if (n == MIN_C) begin
                            m_last <= 1'b1;
                            state  <= TAIL;
                        end else begin
                            m_last <= 1'b0;
                        end
                    end
                end

                DROP: begin
                    if (m_hs) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                    if (s_valid && s_last)
                        state <= TAIL;
                end

                TAIL: begin
                    if (m_hs) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                    if (!m_valid || (m_hs && m_last)) begin
                        byte_cnt     <= '0;
                        frame_padded <= 1'b0;
                        frame_trunc  <= 1'b0;
                        // PASS itself costs one idle cycle before the next byte
                        // appears, so GAP covers the remaining IFG_CYCLES-1.
                        if (IFG_CYCLES <= 1) begin
                            state <= PASS;
                        end else begin
                            gap_cnt <= GAP_W'(IFG_CYCLES);
                            state   <= GAP;
                        end
                    end
                end

                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(2))
                        state <= PASS;
                end

                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_shaper.sv
// Bench for tx_frame_shaper: table of frames through a byte-level scoreboard,
// plus back-to-back gap, random back-pressure and mid-frame reset sequences.
module tb_tx_frame_shaper;

    localparam int MIN_F = 60;
    localparam int MAX_F = 256;
    localparam int IFG   = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [31:0] stat_frames;
    logic [31:0] stat_padded;
    logic [31:0] stat_truncated;
    logic        trunc_pulse;
    logic [2:0]  dbg_state;

    tx_frame_shaper #(
        .MIN_FRAME (MIN_F),
        .MAX_FRAME (MAX_F),
        .IFG_CYCLES(IFG),
        .CNT_W     (16),
        .STAT_W    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .stat_frames   (stat_frames),
        .stat_padded   (stat_padded),
        .stat_truncated(stat_truncated),
        .trunc_pulse   (trunc_pulse),
        .dbg_state     (dbg_state)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard state
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt = 0, trunc_cnt = 0, start_cyc = 0, end_cyc = 0, gap_meas = -1;
    int acc_cnt = 0, first_acc_cyc = 0, drop_waits = 0;
    bit abort = 1'b0;

    typedef struct {
        int len;
        bit udp;
        bit rnd;
        int exp_out;
        int exp_pad;
        int exp_trunc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int i, input bit udp);
        case (i)
            12:      return 8'h08;
            13:      return 8'h00;
            14:      return 8'h45;
            23:      return udp ? 8'h11 : 8'h06;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic monitor();
        logic       prev_stall = 1'b0;
        logic [9:0] prev_out = '0;
        bit         frame_start = 1'b1;
        bit         gap_armed = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall  = 1'b0;
                frame_start = 1'b1;
                gap_armed   = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_while_stalled", {m_valid, m_last, m_data}, prev_out);
                if (m_valid && frame_start) begin
                    start_cyc   = cyc;
                    frame_start = 1'b0;
                    if (gap_armed) begin
                        gap_meas  = cyc - end_cyc - 1;
                        gap_armed = 1'b0;
                    end
                end
                if (trunc_pulse) trunc_cnt++;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", {m_last, m_data}, e);
                    end
                    out_cnt++;
                    if (m_last) begin
                        end_cyc     = cyc;
                        gap_armed   = 1'b1;
                        frame_start = 1'b1;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_out   = {m_valid, m_last, m_data};
            end
        end
    endtask

    // driver: builds the frame, pushes the reference output, then streams it
    task automatic drive_frame(input int len, input bit udp, input bit hold);
        logic [7:0] frm[$];
        int olen;
        int waits;
        for (int i = 0; i < len; i++) frm.push_back(gen_byte(i, udp));
        olen = (len < MIN_F) ? MIN_F : ((len > MAX_F) ? MAX_F : len);
        for (int k = 0; k < olen; k++) begin
            if (k < len) exp_q.push_back({(k == olen - 1), frm[k]});
            else         exp_q.push_back({(k == olen - 1), 8'h00});
        end
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = frm[i];
            s_last  = (i == len - 1);
            waits   = 0;
            @(negedge clk);
            while (!s_ready && !abort && waits < 2000) begin
                waits++;
                @(negedge clk);
            end
            if (abort) break;
            if (waits >= 2000) begin
                check("input_accept_timeout", 64'd1, 64'd0);
                break;
            end
            if (i == 0) first_acc_cyc = cyc;
            if (i >= MAX_F && waits > 0) drop_waits++;
            acc_cnt++;
            @(posedge clk);
            #1;
        end
        if (!hold || abort) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int tot_frames, tot_pad, tot_trunc;
        int out_base, trunc_base, target, t;

        vecs[0]  = '{65,  1'b0, 1'b0, 65,  0, 0};
        vecs[1]  = '{20,  1'b0, 1'b0, 60,  1, 0};
        vecs[2]  = '{293, 1'b1, 1'b0, 256, 0, 1};
        vecs[3]  = '{1,   1'b0, 1'b0, 60,  1, 0};
        vecs[4]  = '{60,  1'b0, 1'b0, 60,  0, 0};
        vecs[5]  = '{59,  1'b1, 1'b0, 60,  1, 0};
        vecs[6]  = '{256, 1'b1, 1'b0, 256, 0, 0};
        vecs[7]  = '{257, 1'b1, 1'b0, 256, 0, 1};
        vecs[8]  = '{30,  1'b0, 1'b1, 60,  1, 0};
        vecs[9]  = '{300, 1'b1, 1'b1, 256, 0, 1};
        vecs[10] = '{40,  1'b0, 1'b1, 60,  1, 0};

        fork
            monitor();
            begin
                #900000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        #2;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_trunc_pulse", trunc_pulse, 0);
        check("rst_stat_frames", stat_frames, 0);
        check("rst_stat_padded", stat_padded, 0);
        check("rst_stat_truncated", stat_truncated, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tot_frames = 0; tot_pad = 0; tot_trunc = 0;
        for (int v = 0; v < 11; v++) begin
            rand_ready = vecs[v].rnd;
            out_base   = out_cnt;
            trunc_base = trunc_cnt;
            drop_waits = 0;
            drive_frame(vecs[v].len, vecs[v].udp, 1'b0);
            wait_drain();
            tot_frames += 1;
            tot_pad    += vecs[v].exp_pad;
            tot_trunc  += vecs[v].exp_trunc;
            check($sformatf("v%0d_out_len", v), out_cnt - out_base, vecs[v].exp_out);
            check($sformatf("v%0d_latency", v), start_cyc - first_acc_cyc, 1);
            check($sformatf("v%0d_trunc_pulses", v), trunc_cnt - trunc_base, vecs[v].exp_trunc);
            check($sformatf("v%0d_drop_stalls", v), drop_waits, 0);
            check($sformatf("v%0d_stat_frames", v), stat_frames, tot_frames);
            check($sformatf("v%0d_stat_padded", v), stat_padded, tot_pad);
            check($sformatf("v%0d_stat_truncated", v), stat_truncated, tot_trunc);
        end
        rand_ready = 1'b0;

        // back-to-back frames with s_valid held high: idle gap length
        gap_meas = -1;
        drive_frame(65, 1'b0, 1'b1);
        drive_frame(65, 1'b0, 1'b0);
        wait_drain();
        tot_frames += 2;
        check("ifg_idle_cycles", gap_meas, IFG);
        check("b2b_stat_frames", stat_frames, tot_frames);

        // asynchronous reset mid-frame, then a clean frame
        abort  = 1'b0;
        target = acc_cnt + 30;
        fork
            drive_frame(100, 1'b0, 1'b0);
            begin
                t = 0;
                while (acc_cnt < target && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 2000) check("reset_trigger_timeout", 64'd1, 64'd0);
                #2;
                rst = 1'b1;
                #1;
                check("mid_rst_m_valid", m_valid, 0);
                check("mid_rst_s_ready", s_ready, 0);
                check("mid_rst_stat_frames", stat_frames, 0);
                check("mid_rst_stat_padded", stat_padded, 0);
                check("mid_rst_stat_truncated", stat_truncated, 0);
                abort = 1'b1;
                repeat (2) @(negedge clk);
                #2;
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_base = out_cnt;
        drive_frame(65, 1'b0, 1'b0);
        wait_drain();
        check("post_rst_out_len", out_cnt - out_base, 65);
        check("post_rst_stat_frames", stat_frames, 1);
        check("post_rst_stat_padded", stat_padded, 0);
        check("post_rst_stat_truncated", stat_truncated, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
